// File: rtl/echo_host_link_if.sv
// Host command / UART byte-link / measurement bundle for echo_host_link.
// master = host and UART side, slave = echo_host_link.
interface echo_host_link_if;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned BYTE_W = 8;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [BYTE_W-1:0] req_arg;
    logic              req_err;

    logic              tx_rdy;
    logic              tx_wen;
    logic [BYTE_W-1:0] tx_data;

    logic              rx_rdy;
    logic              rx_oen;
    logic [BYTE_W-1:0] rx_data;

    logic              meas_valid;
    logic [BYTE_W-1:0] meas_distance;
    logic [BYTE_W-1:0] meas_angle;
    logic              sync_err;

    modport master (
        output req_valid, req_op, req_arg, tx_rdy, rx_rdy, rx_data,
        input  req_ready, req_err, tx_wen, tx_data, rx_oen,
               meas_valid, meas_distance, meas_angle, sync_err
    );

    modport slave (
        input  req_valid, req_op, req_arg, tx_rdy, rx_rdy, rx_data,
        output req_ready, req_err, tx_wen, tx_data, rx_oen,
               meas_valid, meas_distance, meas_angle, sync_err
    );
endinterface

// File: rtl/echo_host_link.sv
// Host command encoder (TX) and telemetry pair decoder (RX) for an echo sounder UART link.
// Optional ECHO_LINK_STATS_EN adds saturating pair_count / err_count outputs.
module echo_host_link (
    input  logic clk,
    input  logic rst_n,
    echo_host_link_if.slave bus
`ifdef ECHO_LINK_STATS_EN
    ,
    output logic [15:0] pair_count,
    output logic [15:0] err_count
`endif
);
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 2;

    localparam logic [OW-1:0] OP_SET_ANGLE = 2'b00;
    localparam logic [OW-1:0] OP_SET_MODE  = 2'b01;
    localparam logic [OW-1:0] OP_MEASURE   = 2'b10;

    typedef enum logic [1:0] {T_IDLE, T_WAIT_RDY, T_SEND} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_CLR} rx_state_t;

    tx_state_t tx_state, tx_state_d;
    rx_state_t rx_state, rx_state_d;

    logic [DW-1:0] tx_data_q, tx_data_d;
    logic [DW-1:0] second_q, second_d;
    logic          pend_q, pend_d;
    logic          tx_wen_q, req_ready_q;
    logic          req_err_q, req_err_d;

    logic          rx_oen_q;
    logic          expect_angle_q, expect_angle_d;
    logic [DW-1:0] held_q, held_d;
    logic [DW-1:0] meas_dist_q, meas_dist_d;
    logic [DW-1:0] meas_ang_q, meas_ang_d;
    logic          meas_valid_q, meas_valid_d;
    logic          sync_err_q, sync_err_d;

    // TX: encode the accepted request, then pace bytes with the tx_rdy/tx_wen handshake
    always_comb begin
        tx_state_d = tx_state;
        tx_data_d  = tx_data_q;
        second_d   = second_q;
        pend_d     = pend_q;
        req_err_d  = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    tx_state_d = T_WAIT_RDY;
                    case (bus.req_op)
                        OP_SET_ANGLE: begin
                            tx_data_d = 8'h00;
                            second_d  = bus.req_arg;
                            pend_d    = 1'b1;
                        end
                        OP_SET_MODE: tx_data_d = {7'b0000_010, bus.req_arg[0]};
                        OP_MEASURE:  tx_data_d = 8'h08;
                        default: begin
                            // SET_RANGE: end nibble must be non-zero on the wire
                            if (bus.req_arg[7:4] != 4'h0) begin
                                tx_data_d = bus.req_arg;
                            end else if (bus.req_arg[3:0] != 4'h0) begin
                                tx_data_d = {bus.req_arg[3:0], bus.req_arg[7:4]};
                            end else begin
                                tx_state_d = T_IDLE;
                                req_err_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            T_WAIT_RDY: begin
                if (bus.tx_rdy) tx_state_d = T_SEND;
            end
            T_SEND: begin
                if (!bus.tx_rdy) begin
                    if (pend_q) begin
                        tx_state_d = T_WAIT_RDY;
                        tx_data_d  = second_q;
                        pend_d     = 1'b0;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // RX: one byte per rx_rdy assertion, decoded at capture; tag bit 0 distinguishes angle
    always_comb begin
        rx_state_d     = rx_state;
        expect_angle_d = expect_angle_q;
        held_d         = held_q;
        meas_dist_d    = meas_dist_q;
        meas_ang_d     = meas_ang_q;
        meas_valid_d   = 1'b0;
        sync_err_d     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (bus.rx_rdy) begin
                    rx_state_d = R_ACK;
                    if (!expect_angle_q) begin
                        if (!bus.rx_data[0]) begin
                            held_d         = bus.rx_data;
                            expect_angle_d = 1'b1;
                        end else begin
                            sync_err_d = 1'b1;
                        end
                    end else if (bus.rx_data[0]) begin
                        meas_dist_d    = held_q;
                        meas_ang_d     = {bus.rx_data[7:1], 1'b0};
                        meas_valid_d   = 1'b1;
                        expect_angle_d = 1'b0;
                    end else begin
                        held_d     = bus.rx_data;
                        sync_err_d = 1'b1;
                    end
                end
            end
            R_ACK:   rx_state_d = R_CLR;
            R_CLR: begin
                if (!bus.rx_rdy) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state       <= T_IDLE;
            tx_data_q      <= '0;
            second_q       <= '0;
            pend_q         <= 1'b0;
            tx_wen_q       <= 1'b1;
            req_ready_q    <= 1'b1;
            req_err_q      <= 1'b0;
            rx_state       <= R_IDLE;
            rx_oen_q       <= 1'b1;
            expect_angle_q <= 1'b0;
            held_q         <= '0;
            meas_dist_q    <= '0;
            meas_ang_q     <= '0;
            meas_valid_q   <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            tx_state       <= tx_state_d;
            tx_data_q      <= tx_data_d;
            second_q       <= second_d;
            pend_q         <= pend_d;
            tx_wen_q       <= (tx_state_d != T_SEND);
            req_ready_q    <= (tx_state_d == T_IDLE);
            req_err_q      <= req_err_d;
            rx_state       <= rx_state_d;
            rx_oen_q       <= (rx_state_d != R_ACK);
            expect_angle_q <= expect_angle_d;
            held_q         <= held_d;
            meas_dist_q    <= meas_dist_d;
            meas_ang_q     <= meas_ang_d;
            meas_valid_q   <= meas_valid_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.req_err       = req_err_q;
    assign bus.tx_wen        = tx_wen_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.rx_oen        = rx_oen_q;
    assign bus.meas_valid    = meas_valid_q;
    assign bus.meas_distance = meas_dist_q;
    assign bus.meas_angle    = meas_ang_q;
    assign bus.sync_err      = sync_err_q;

`ifdef ECHO_LINK_STATS_EN
    localparam int unsigned CW = 16;

    logic [1:0]  err_inc;
    logic [CW:0] err_sum;

    // Both error pulses can land in one cycle; count each, saturating
    always_comb begin
        err_inc = 2'(req_err_d) + 2'(sync_err_d);
        err_sum = (CW+1)'(err_count) + (CW+1)'(err_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_count <= '0;
            err_count  <= '0;
        end else begin
            if (meas_valid_d && (pair_count != {CW{1'b1}})) pair_count <= pair_count + CW'(1);
            err_count <= err_sum[CW] ? {CW{1'b1}} : err_sum[CW-1:0];
        end
    end
`endif
endmodule

// File: doc/echo_host_link.md
ECHO_HOST_LINK -- requirements
Module: echo_host_link

Interface
REQ-001 clk  in  1  single system clock; all logic on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  host command request present.
REQ-004 req_ready  out  1  block accepts request this cycle; high only in T_IDLE.
REQ-005 req_op  in  2  00 SET_ANGLE, 01 SET_MODE, 10 MEASURE, 11 SET_RANGE.
REQ-006 req_arg  in  8  angle (SET_ANGLE); bit0 mode, 0 auto / 1 manual (SET_MODE); [7:4] end nibble, [3:0] start nibble (SET_RANGE); ignored for MEASURE.
REQ-007 req_err  out  1  one-cycle pulse: SET_RANGE request dropped.
REQ-008 tx_rdy  in  1  UART transmitter idle.
REQ-009 tx_wen  out  1  active-low byte write strobe.
REQ-010 tx_data  out  8  command byte to transmitter.
REQ-011 rx_rdy  in  1  UART receiver holds a byte.
REQ-012 rx_oen  out  1  active-low read acknowledge.
REQ-013 rx_data  in  8  received telemetry byte.
REQ-014 meas_valid  out  1  one-cycle pulse: new measurement pair.
REQ-015 meas_distance  out  8  distance byte, LSB forced 0.
REQ-016 meas_angle  out  8  angle byte, LSB forced 0.
REQ-017 sync_err  out  1  one-cycle pulse: telemetry tag out of order.

Function
REQ-018 The encoder SHALL map requests to bytes: SET_ANGLE -> 0x00 then req_arg; SET_MODE -> 0x04|req_arg[0]; MEASURE -> 0x08; SET_RANGE -> single byte per REQ-019.
REQ-019 SET_RANGE SHALL send req_arg if req_arg[7:4]!=0, send nibble-swapped {req_arg[3:0],req_arg[7:4]} if req_arg[7:4]==0 and req_arg[3:0]!=0, and send nothing but pulse req_err the cycle after acceptance if req_arg==0x00 (or 0x?0 never needs swap).
REQ-020 Request acceptance SHALL be req_valid & req_ready; req_op/req_arg captured that edge, later changes ignored.
REQ-021 TX FSM states SHALL be T_IDLE -> T_WAIT_RDY (until tx_rdy) -> T_SEND (tx_wen=0, tx_data stable, until tx_rdy==0) -> T_WAIT_RDY for second SET_ANGLE byte, else T_IDLE.
REQ-022 tx_wen SHALL be low only in T_SEND; tx_data SHALL remain stable from T_WAIT_RDY entry until T_SEND exit.
REQ-023 RX FSM states SHALL be R_IDLE -> (rx_rdy) R_ACK: capture rx_data, rx_oen=0 one cycle -> R_CLR: rx_oen=1, wait rx_rdy==0 -> R_IDLE; one byte per rx_rdy assertion.
REQ-024 Decoder SHALL expect distance (LSB 0) then angle (LSB 1); pair complete -> meas_distance/meas_angle updated and meas_valid pulsed the cycle after angle capture.
REQ-025 Angle byte while expecting distance SHALL be discarded with sync_err pulse; distance byte while expecting angle SHALL replace held distance with sync_err pulse.
REQ-026 TX and RX paths SHALL operate concurrently and independently; simultaneous request acceptance and byte capture both complete.
REQ-027 meas_distance/meas_angle SHALL hold their last values between pairs.

Reset
REQ-028 On rst_n low, immediately: T_IDLE, R_IDLE, decoder expects distance, req_ready=1 after release, tx_wen=1, rx_oen=1, tx_data=0, meas_*=0, meas_valid=0, req_err=0, sync_err=0.
REQ-029 Reset mid-transfer SHALL abort any partially sent SET_ANGLE pair and drop any held distance byte; no resend after release.

Configuration
REQ-030 With ECHO_LINK_STATS_EN defined, the block SHALL add outputs pair_count[15:0] (increment per meas_valid) and err_count[15:0] (increment per sync_err or req_err), both saturating at 0xFFFF, reset to 0; without it these ports and counters SHALL not exist.

Verification
REQ-031 SET_ANGLE arg 0x5A, tx_rdy handshakes -> tx bytes 0x00 then 0x5A, tx_wen low exactly during each T_SEND.
REQ-032 SET_RANGE arg 0x03 -> single byte 0x30; arg 0x00 -> no tx_wen, req_err pulse one cycle.
REQ-033 RX bytes 0x40, 0x21 -> meas_valid pulse, meas_distance=0x40, meas_angle=0x20, sync_err=0.
REQ-034 RX bytes 0x21, 0x40, 0x42, 0x11 -> sync_err twice, one meas_valid with distance 0x42, angle 0x10.
REQ-035 rst_n asserted between first and second SET_ANGLE byte -> tx_wen=1 immediately, second byte never sent, req_ready=1 after release.
REQ-036 With ECHO_LINK_STATS_EN, 3 valid pairs plus 1 stray angle byte -> pair_count=3, err_count=1.
